seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller, next generation of the vending-machine display driver.

---
 rtl/seg7_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered frame, blink, dp, PWM brightness, dead time.
// Latency: bit/seg outputs are registered, one cycle behind the scan position; load_ack/frame_start likewise.
// Backpressure: none; load is a fire-and-forget strobe, last load before a frame boundary wins.
//
// Ports:
//   i_sys_clk, i_sys_rst        clock, synchronous active-high reset
//   i_frame_codes               5-bit glyph code per digit, digit i at [5i+4:5i], digit 0 rightmost
//   i_blink_mask, i_dp_mask     per-digit blink enable / decimal point enable
//   i_load                      strobe: capture codes and masks into the shadow frame
//   i_brightness                0 = 1/16 of slot lit, 15 = full slot (minus dead time)
//   o_load_ack                  pulse when the shadow frame becomes active
//   o_frame_start               pulse when the scan wraps back to digit 0
//   o_bit_select, o_seg_select  active-low digit enables / segments ([7] = dp, [6:0] = g..a)
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100_000,
    parameter int BLINK_DIV  = 50_000_000
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic [5*NUM_DIGITS-1:0]   i_frame_codes,
    input  logic [NUM_DIGITS-1:0]     i_blink_mask,
    input  logic [NUM_DIGITS-1:0]     i_dp_mask,
    input  logic                      i_load,
    input  logic [3:0]                i_brightness,
    output logic                      o_load_ack,
    output logic                      o_frame_start,
    output logic [NUM_DIGITS-1:0]     o_bit_select,
    output logic [7:0]                o_seg_select
);

    // The slot is split into 16 equal brightness phases. Instead of dividing the
    // slot counter, the slot position is kept as {phase, sub-count within phase}.
    localparam int SLOT_DIV = SCAN_DIV / 16;
    localparam int SUB_W    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [5*NUM_DIGITS-1:0] BLANK_FRAME = {NUM_DIGITS{5'd19}};

    logic [SUB_W-1:0]          r_sub;
    logic [3:0]                r_phase;
    logic [IDX_W-1:0]          r_idx;
    logic [BLK_W-1:0]          r_blink_cnt;
    logic                      r_blink_on;

    logic [5*NUM_DIGITS-1:0]   r_act_codes;
    logic [NUM_DIGITS-1:0]     r_act_blink;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [5*NUM_DIGITS-1:0]   r_sh_codes;
    logic [NUM_DIGITS-1:0]     r_sh_blink;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic                      r_pending;

    logic                      w_phase_end;
    logic                      w_slot_end;
    logic                      w_boundary;
    logic                      w_dead;
    logic                      w_blink_hide;
    logic                      w_drive;
    logic [4:0]                w_code;
    logic [6:0]                w_glyph;
    logic [NUM_DIGITS-1:0]     w_onehot;

    function automatic logic [6:0] glyph_lut(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            5'd16:   seg = 7'h3F;
            5'd17:   seg = 7'h2F;
            5'd18:   seg = 7'h23;
            5'd20:   seg = 7'h1C;
            5'd21:   seg = 7'h7C;
            5'd22:   seg = 7'h5E;
            5'd23:   seg = 7'h63;
            5'd24:   seg = 7'h2B;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign w_phase_end  = (r_sub == SUB_W'(SLOT_DIV - 1));
    assign w_slot_end   = w_phase_end && (r_phase == 4'd15);
    assign w_boundary   = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    // First cycle of every slot is dead time so the previous digit's segments
    // never bleed into the next digit while the drivers switch.
    assign w_dead       = (r_sub == '0) && (r_phase == 4'd0);
    assign w_blink_hide = r_act_blink[r_idx] && !r_blink_on;
    assign w_drive      = (r_phase <= i_brightness) && !w_dead && !w_blink_hide;
    assign w_code       = r_act_codes[5*r_idx +: 5];
    assign w_glyph      = glyph_lut(w_code);
    assign w_onehot     = NUM_DIGITS'(1) << r_idx;

    // Scan position
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_sub   <= '0;
            r_phase <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_sub   <= '0;
            r_phase <= '0;
            r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else if (w_phase_end) begin
            r_sub   <= '0;
            r_phase <= r_phase + 4'd1;
        end else begin
            r_sub   <= r_sub + 1'b1;
        end
    end

    // Blink timebase, free-running
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= !r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Double buffer. The active frame only changes at the frame boundary, so a
    // frame is never shown half old / half new. A load on the boundary cycle
    // lands in the shadow and leaves pending set for the next boundary.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_act_codes <= BLANK_FRAME;
            r_act_blink <= '0;
            r_act_dp    <= '0;
            r_sh_codes  <= BLANK_FRAME;
            r_sh_blink  <= '0;
            r_sh_dp     <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_act_codes <= r_sh_codes;
                r_act_blink <= r_sh_blink;
                r_act_dp    <= r_sh_dp;
            end
            if (i_load) begin
                r_sh_codes <= i_frame_codes;
                r_sh_blink <= i_blink_mask;
                r_sh_dp    <= i_dp_mask;
                r_pending  <= 1'b1;
            end else if (w_boundary) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // Registered pin drivers and status pulses
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            o_bit_select  <= '1;
            o_seg_select  <= 8'hFF;
            o_load_ack    <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_load_ack    <= w_boundary && r_pending;
            o_frame_start <= w_boundary;
            if (w_drive) begin
                o_bit_select <= ~w_onehot;
                o_seg_select <= {~r_act_dp[r_idx], w_glyph};
            end else begin
                o_bit_select <= '1;
                o_seg_select <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=32, BLINK_DIV=256.
// A reference model queues the expected pin state each clock; it is popped and compared on the falling edge.
// Directed scenarios add aggregate checks (ack counts, lit-cycle counts) on top of the per-cycle compare.
module tb_seg7_scan_ctrl;

    localparam int ND   = 4;
    localparam int SDIV = 32;
    localparam int BDIV = 256;

    logic            clk;
    logic            rst;
    logic [5*ND-1:0] frame_codes;
    logic [ND-1:0]   blink_mask;
    logic [ND-1:0]   dp_mask;
    logic            load;
    logic [3:0]      brightness;
    logic            load_ack;
    logic            frame_start;
    logic [ND-1:0]   bit_select;
    logic [7:0]      seg_select;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SDIV),
        .BLINK_DIV (BDIV)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_rst    (rst),
        .i_frame_codes(frame_codes),
        .i_blink_mask (blink_mask),
        .i_dp_mask    (dp_mask),
        .i_load       (load),
        .i_brightness (brightness),
        .o_load_ack   (load_ack),
        .o_frame_start(frame_start),
        .o_bit_select (bit_select),
        .o_seg_select (seg_select)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_ref(input int c);
        case (c)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
           16: return 7'h3F;  17: return 7'h2F;  18: return 7'h23;  20: return 7'h1C;
           21: return 7'h7C;  22: return 7'h5E;  23: return 7'h63;  24: return 7'h2B;
           default: return 7'h7F;
        endcase
    endfunction

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [ND-1:0] bs;
        logic [7:0]    seg;
        logic          ack;
        logic          fs;
    } exp_t;

    exp_t sb_q[$];

    int          m_scan, m_idx, m_bcnt;
    bit          m_bon, m_pending;
    int          m_act[ND];
    int          m_sh[ND];
    logic [ND-1:0] m_act_blink, m_act_dp, m_sh_blink, m_sh_dp;

    always @(posedge clk) begin
        exp_t e;
        bit   bnd;
        bit   drv;
        if (rst) begin
            e = '{bs: '1, seg: 8'hFF, ack: 1'b0, fs: 1'b0};
            m_scan = 0; m_idx = 0; m_bcnt = 0; m_bon = 1; m_pending = 0;
            for (int i = 0; i < ND; i++) begin
                m_act[i] = 19;
                m_sh[i]  = 19;
            end
            m_act_blink = '0; m_act_dp = '0; m_sh_blink = '0; m_sh_dp = '0;
        end else begin
            bnd = (m_scan == SDIV - 1) && (m_idx == ND - 1);
            drv = (m_scan != 0) && ((m_scan / (SDIV / 16)) <= int'(brightness))
                  && !(m_act_blink[m_idx] && !m_bon);
            e.bs  = drv ? ~(ND'(1) << m_idx) : '1;
            e.seg = drv ? {~m_act_dp[m_idx], glyph_ref(m_act[m_idx])} : 8'hFF;
            e.ack = bnd && m_pending;
            e.fs  = bnd;
            if (bnd && m_pending) begin
                m_act       = m_sh;
                m_act_blink = m_sh_blink;
                m_act_dp    = m_sh_dp;
            end
            if (bnd) m_pending = 0;
            if (load) begin
                for (int i = 0; i < ND; i++) m_sh[i] = int'(frame_codes[5*i +: 5]);
                m_sh_blink = blink_mask;
                m_sh_dp    = dp_mask;
                m_pending  = 1;
            end
            if (m_scan == SDIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % ND;
            end else begin
                m_scan++;
            end
            if (m_bcnt == BDIV - 1) begin
                m_bcnt = 0;
                m_bon  = !m_bon;
            end else begin
                m_bcnt++;
            end
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("bit_select",  32'(bit_select),  32'(e.bs));
            check_val("seg_select",  32'(seg_select),  32'(e.seg));
            check_val("load_ack",    32'(load_ack),    32'(e.ack));
            check_val("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (load_ack) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [5*ND-1:0] codes, input logic [ND-1:0] bm, input logic [ND-1:0] dm);
        frame_codes = codes;
        blink_mask  = bm;
        dp_mask     = dm;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c0, c1, c2;

        rst = 1'b1; load = 1'b0; frame_codes = '0;
        blink_mask = '0; dp_mask = '0; brightness = 4'd15;
        cyc(2);
        check_val("rst_bit_select", 32'(bit_select), 32'hF);
        check_val("rst_seg_select", 32'(seg_select), 32'hFF);
        check_val("rst_load_ack",   32'(load_ack),   32'h0);
        rst = 1'b0;

        // blank display for a whole frame
        c0 = 0;
        for (int i = 0; i < 4*SDIV; i++) begin
            @(negedge clk);
            if (seg_select == 8'hFF) c0++;
        end
        check_val("blank_frame", 32'(c0), 32'(4*SDIV));

        // digits 3..0 = 3,2,1,0
        do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
        wait_ack(200, ok);
        check_val("ack_0123_seen", 32'(ok), 32'h1);
        check_val("ack_with_fs",   32'(frame_start), 32'h1);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 4*SDIV; i++) begin
            @(negedge clk);
            if (bit_select == 4'b1110 && seg_select == 8'hC0) c0++;
            if (bit_select == 4'b0111 && seg_select == 8'hB0) c1++;
        end
        check_val("digit0_C0_cycles", 32'(c0), 32'd31);
        check_val("digit3_B0_cycles", 32'(c1), 32'd31);

        // two loads inside one frame: last wins, single ack
        do_load({4{5'd10}}, 4'b0000, 4'b0000);
        cyc(3);
        do_load({4{5'd8}}, 4'b0000, 4'b0000);
        wait_ack(200, ok);
        check_val("ack_double_seen", 32'(ok), 32'h1);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 4*SDIV; i++) begin
            @(negedge clk);
            if (load_ack) c1++;
            if (seg_select == 8'h80) c0++;
        end
        check_val("double_load_acks", 32'(c1), 32'd0);
        check_val("all8_cycles",      32'(c0), 32'd124);

        // brightness 7: 15 lit cycles per slot
        brightness = 4'd7;
        cyc(1);
        c0 = 0;
        for (int i = 0; i < 4*SDIV; i++) begin
            @(negedge clk);
            if (bit_select != 4'hF) c0++;
        end
        check_val("bright7_lit", 32'(c0), 32'd60);
        brightness = 4'd15;

        // blink digit 0
        do_load({4{5'd8}}, 4'b0001, 4'b0000);
        wait_ack(200, ok);
        check_val("ack_blink_seen", 32'(ok), 32'h1);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 4*BDIV; i++) begin
            @(negedge clk);
            if (bit_select == 4'b1110) c0++;
            if (bit_select == 4'b1101) c1++;
        end
        check_val("blink_digit0_lit", 32'(c0), 32'd124);
        check_val("blink_digit1_lit", 32'(c1), 32'd248);

        // decimal point on digit 1, code 5
        do_load({4{5'd5}}, 4'b0000, 4'b0010);
        wait_ack(200, ok);
        check_val("ack_dp_seen", 32'(ok), 32'h1);
        c0 = 0; c2 = 0;
        for (int i = 0; i < 4*SDIV; i++) begin
            @(negedge clk);
            if (bit_select == 4'b1101 && seg_select == 8'h12) c0++;
            if (bit_select == 4'b1110 && seg_select == 8'h92) c2++;
        end
        check_val("dp_digit1_12", 32'(c0), 32'd31);
        check_val("dp_digit0_92", 32'(c2), 32'd31);
        check_val("frame_period", 32'(frame_start), 32'h1);

        // load exactly on the boundary cycle: applied one frame later
        cyc(4*SDIV - 1);
        do_load({4{5'd1}}, 4'b0000, 4'b0000);
        check_val("bnd_load_fs",    32'(frame_start), 32'h1);
        check_val("bnd_load_noack", 32'(load_ack),    32'h0);
        wait_ack(4*SDIV + 8, ok);
        check_val("bnd_load_ack_next", 32'(ok), 32'h1);
        check_val("bnd_load_ack_fs",   32'(frame_start), 32'h1);

        // reset mid-frame drops a pending load
        cyc(10);
        do_load({4{5'd2}}, 4'b0000, 4'b1111);
        cyc(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_bit_select", 32'(bit_select), 32'hF);
        check_val("midrst_seg_select", 32'(seg_select), 32'hFF);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (load_ack) c1++;
            if (seg_select != 8'hFF) c0++;
        end
        check_val("midrst_acks",    32'(c1), 32'd0);
        check_val("midrst_visible", 32'(c0), 32'd0);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
